// File: rtl/iob_modcnt_seq.sv
// Sequencer for a downstream modulo counter: clears it, issues prescaled
// enable ticks, counts completed periods and reports done/err/aborted.
module iob_modcnt_seq #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PRESC_W = 16,
  parameter int unsigned NCYC_W  = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0]  period,
  input  logic [DATA_W-1:0]  phase,
  input  logic [PRESC_W-1:0] presc,
  input  logic [NCYC_W-1:0]  ncycles,
  input  logic [DATA_W-1:0]  cnt,
  output logic              cnt_rst,
  output logic              cnt_en,
  output logic [DATA_W-1:0]  cnt_load_val,
  output logic [DATA_W-1:0]  cnt_mod,
  output logic              busy,
  output logic              wrap,
  output logic              done,
  output logic [NCYC_W-1:0]  cycles_done,
  output logic              err,
  output logic              aborted
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CLR  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [DATA_W-1:0]  period_q, period_d;
  logic [DATA_W-1:0]  phase_q, phase_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [NCYC_W-1:0]  ncyc_q, ncyc_d;
  logic [PRESC_W-1:0] pc_q, pc_d;
  logic               first_tick_q, first_tick_d;
  logic [NCYC_W-1:0]  cycles_done_q, cycles_done_d;
  logic               err_q, err_d;
  logic               aborted_q, aborted_d;
  logic               wrap_q, wrap_d;

  logic               tick;
  logic [DATA_W-1:0]  period_m1;
  logic [NCYC_W-1:0]  cycles_inc;

  // Wrap compare stays at DATA_W bits so period_r-1 never sign-extends.
  assign period_m1  = period_q - DATA_W'(1);
  assign cycles_inc = cycles_done_q + NCYC_W'(1);
  // rst also masks the tick so nothing advances in a reset cycle.
  assign tick = (state_q == RUN) && (pc_q == presc_q) && !abort && !rst;

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    phase_d       = phase_q;
    presc_d       = presc_q;
    ncyc_d        = ncyc_q;
    pc_d          = pc_q;
    first_tick_d  = first_tick_q;
    cycles_done_d = cycles_done_q;
    err_d         = err_q;
    aborted_d     = aborted_q;
    wrap_d        = 1'b0;
    if (rst) begin
      state_d       = IDLE;
      period_d      = '0;
      phase_d       = '0;
      presc_d       = '0;
      ncyc_d        = '0;
      pc_d          = '0;
      first_tick_d  = 1'b0;
      cycles_done_d = '0;
      err_d         = 1'b0;
      aborted_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            period_d      = period;
            phase_d       = phase;
            presc_d       = presc;
            ncyc_d        = ncycles;
            cycles_done_d = '0;
            err_d         = 1'b0;
            aborted_d     = 1'b0;
            if ((period == '0) || (ncycles == '0) || (phase >= period)) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              state_d = CLR;
            end
          end
        end
        CLR: begin
          pc_d         = '0;
          first_tick_d = 1'b1;
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = DONE;
          end else if (tick) begin
            pc_d = '0;
            if (first_tick_q) begin
              first_tick_d = 1'b0;
            end else if (cnt == period_m1) begin
              wrap_d        = 1'b1;
              cycles_done_d = cycles_inc;
              if (cycles_inc == ncyc_q) state_d = DONE;
            end
          end else begin
            pc_d = pc_q + PRESC_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= IDLE;
      period_q      <= '0;
      phase_q       <= '0;
      presc_q       <= '0;
      ncyc_q        <= '0;
      pc_q          <= '0;
      first_tick_q  <= 1'b0;
      cycles_done_q <= '0;
      err_q         <= 1'b0;
      aborted_q     <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      phase_q       <= phase_d;
      presc_q       <= presc_d;
      ncyc_q        <= ncyc_d;
      pc_q          <= pc_d;
      first_tick_q  <= first_tick_d;
      cycles_done_q <= cycles_done_d;
      err_q         <= err_d;
      aborted_q     <= aborted_d;
      wrap_q        <= wrap_d;
    end
  end

  assign cnt_rst      = (state_q == CLR);
  assign cnt_en       = tick;
  assign cnt_load_val = phase_q;
  assign cnt_mod      = period_q;
  assign busy         = (state_q == CLR) || (state_q == RUN);
  assign wrap         = wrap_q;
  assign done         = (state_q == DONE);
  assign cycles_done  = cycles_done_q;
  assign err          = err_q;
  assign aborted      = aborted_q;

endmodule

// File: tb/tb_iob_modcnt_seq.sv
// Scoreboard bench for iob_modcnt_seq with a behavioural downstream counter.
module tb_iob_modcnt_seq;

  logic       clk, arst, rst, start, abort;
  logic [7:0] period, phase, cnt_m;
  logic [3:0] presc, ncycles;
  logic       cnt_rst, cnt_en, busy, wrap, done, err, aborted;
  logic [7:0] cnt_load_val, cnt_mod;
  logic [3:0] cycles_done;

  iob_modcnt_seq #(.DATA_W(8), .PRESC_W(4), .NCYC_W(4)) dut (
    .clk(clk), .arst(arst), .rst(rst), .start(start), .abort(abort),
    .period(period), .phase(phase), .presc(presc), .ncycles(ncycles),
    .cnt(cnt_m), .cnt_rst(cnt_rst), .cnt_en(cnt_en),
    .cnt_load_val(cnt_load_val), .cnt_mod(cnt_mod), .busy(busy),
    .wrap(wrap), .done(done), .cycles_done(cycles_done), .err(err),
    .aborted(aborted)
  );

  typedef struct {int cyc; int cd;} wrap_t;
  typedef struct {int cyc; int err; int ab; int cd;} done_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 0;
  bit    loaded;
  int    exp_rst[$];
  int    exp_tick[$];
  wrap_t exp_wrap[$];
  done_t exp_done[$];

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream modulo counter: first enable after cnt_rst loads the phase.
  always @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_m <= 0; loaded <= 0;
    end else if (cnt_rst) begin
      cnt_m <= 0; loaded <= 0;
    end else if (cnt_en) begin
      if (!loaded) begin
        cnt_m <= cnt_load_val; loaded <= 1;
      end else begin
        cnt_m <= (cnt_m == cnt_mod - 8'd1) ? 8'd0 : cnt_m + 8'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] outs();
    return {37'd0, cnt_rst, cnt_en, cnt_load_val, cnt_mod, busy, wrap, done,
            cycles_done, err, aborted};
  endfunction

  // Monitor: every DUT event pops the next expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cnt_rst) begin
        if (exp_rst.size() == 0) check("cnt_rst_unexpected", 1, 0);
        else check("cnt_rst_cycle", cyc, exp_rst.pop_front());
      end
      if (cnt_en) begin
        if (exp_tick.size() == 0) check("tick_unexpected", 1, 0);
        else check("tick_cycle", cyc, exp_tick.pop_front());
      end
      if (wrap) begin
        if (exp_wrap.size() == 0) check("wrap_unexpected", 1, 0);
        else begin
          wrap_t w;
          w = exp_wrap.pop_front();
          check("wrap_cycle", cyc, w.cyc);
          check("wrap_cycles_done", cycles_done, w.cd);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else begin
          done_t d;
          d = exp_done.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("done_err", err, d.err);
          check("done_aborted", aborted, d.ab);
          check("done_cycles_done", cycles_done, d.cd);
        end
      end
    end
  end

  function automatic int pending();
    return exp_rst.size() + exp_tick.size() + exp_wrap.size() + exp_done.size();
  endfunction

  task automatic flush();
    exp_rst.delete(); exp_tick.delete(); exp_wrap.delete(); exp_done.delete();
  endtask

  // One sequence; ab_off/sb_off (cycles after start, 0 = none) inject abort / busy start.
  task automatic run_seq(input int p, input int ph, input int ps, input int nc,
                         input int ab_off, input int sb_off);
    int c, a, ntick, tc, nw, last_pulse, ecd, eab, eerr;
    bit bad, fin;
    @(posedge clk); #1;
    period = 8'(p); phase = 8'(ph); presc = 4'(ps); ncycles = 4'(nc); start = 1;
    c = cyc;
    bad = (p == 0) || (nc == 0) || (ph >= p);
    a = (ab_off != 0) ? c + ab_off : 32'h4000_0000;
    eerr = 0; eab = 0; ecd = 0; nw = 0; last_pulse = 0;
    if (bad) begin
      eerr = 1;
      exp_done.push_back('{c + 1, 1, 0, 0});
    end else begin
      exp_rst.push_back(c + 1);
      ntick = 1 + (p - 1 - ph) + 1 + (nc - 1) * p;
      for (int j = 1; j <= ntick; j++) begin
        tc = c + 1 + j * (ps + 1);
        if (tc < a) exp_tick.push_back(tc);
      end
      for (int k = 1; k <= nc; k++) begin
        tc = c + 1 + ((p - ph + 1) + (k - 1) * p) * (ps + 1);
        if (tc < a) begin
          exp_wrap.push_back('{tc + 1, k});
          nw = k; last_pulse = tc + 1;
        end
      end
      if (ab_off != 0) begin
        eab = 1; ecd = nw;
        exp_done.push_back('{a + 1, 0, 1, nw});
      end else begin
        ecd = nc;
        exp_done.push_back('{last_pulse, 0, 0, nc});
      end
    end
    fin = 0;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(posedge clk); #1;
      start = 0;
      if (sb_off != 0 && cyc == c + sb_off) begin
        start = 1; period = 8'(p + 3); phase = 8'd0;
      end
      if (sb_off != 0 && cyc == c + sb_off + 1) check("busy_start_cnt_mod", cnt_mod, p);
      abort = (ab_off != 0) && (cyc == a);
      if (pending() == 0) fin = 1;
    end
    if (!fin) check("sequence_timeout", 1, 0);
    start = 0; abort = 0;
    repeat (2) @(posedge clk);
    #1;
    check("end_busy", busy, 0);
    check("end_cycles_done", cycles_done, ecd);
    check("end_err", err, eerr);
    check("end_aborted", aborted, eab);
    flush();
  endtask

  initial begin
    arst = 1; rst = 0; start = 0; abort = 0;
    period = 0; phase = 0; presc = 0; ncycles = 0;
    repeat (3) @(posedge clk);
    #1 check("arst_outputs", outs(), 0);
    arst = 0;
    @(posedge clk); #1 check("post_arst_outputs", outs(), 0);
    mon_en = 1;

    run_seq(4, 2, 0, 2, 0, 0);       // full run, 7 ticks
    run_seq(3, 0, 2, 1, 0, 0);       // prescaler
    run_seq(5, 5, 0, 1, 0, 0);       // phase >= period
    run_seq(0, 0, 0, 1, 0, 0);       // period == 0
    run_seq(5, 0, 0, 0, 0, 0);       // ncycles == 0
    run_seq(4, 0, 0, 3, 7, 0);       // abort in first wrap cycle
    run_seq(4, 0, 0, 3, 1, 0);       // abort in CLR
    run_seq(1, 0, 0, 3, 0, 0);       // period 1
    run_seq(255, 253, 1, 1, 0, 0);   // top of DATA_W range
    run_seq(4, 1, 1, 2, 0, 3);       // start while busy

    // Abort in IDLE is ignored and status holds.
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    @(posedge clk); #1;
    check("idle_abort_aborted", aborted, 0);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_cycles_done", cycles_done, 2);

    // Synchronous reset mid-run wins over start/abort.
    mon_en = 0;
    period = 8'd4; phase = 8'd0; presc = 4'd0; ncycles = 4'd3; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1; start = 1; abort = 1;
    @(posedge clk); #1 rst = 0; start = 0; abort = 0;
    check("sync_rst_outputs", outs(), 0);
    flush(); mon_en = 1;
    repeat (6) @(posedge clk);
    #1 check("sync_rst_idle", outs(), 0);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    mon_en = 0;
    period = 8'd4; phase = 8'd1; presc = 4'd0; ncycles = 4'd3; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (4) @(posedge clk);
    #2 arst = 1;
    #1 check("arst_midrun_outputs", outs(), 0);
    @(posedge clk); #1 arst = 0;
    flush(); mon_en = 1;
    repeat (6) @(posedge clk);
    #1 check("arst_midrun_idle", outs(), 0);

    run_seq(2, 1, 0, 2, 0, 0);       // recovery after resets

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
